mem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU datapath and the `Memory` block, driving its `mem_read`/`mem_write`/address/data port. It accepts one byte, halfword or word request at a time over a valid/ready handshake. Sub-word stores are performed as read-modify-write on the containing word. Load data is returned sign- or zero-extended with a single-cycle response pulse.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word requests to a word-wide memory port.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned half/word requests instead of masking.
module mem_access_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_cnt;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_off;
    logic [31:0]           r_wdata;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [31:0]           r_mem_wdata;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;

    logic                  w_accept;
    logic                  w_req_word;
    logic                  w_trap;
    logic                  w_rd_last;
    logic [1:0]            w_lane;
    logic [4:0]            w_shamt;
    logic [31:0]           w_shift;
    logic [31:0]           w_load;
    logic [31:0]           w_mask;
    logic [31:0]           w_merged;

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign w_req_word = req_size[1];
    assign w_rd_last  = (r_state == S_READ) && (r_cnt == LAST);

`ifdef MAU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_resp_error;

    assign w_misalign = ((req_size == 2'b01) && req_addr[0])
                      || (w_req_word && (req_addr[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign resp_error = r_resp_error;

    always_ff @(posedge clk) begin
        if (reset)
            r_resp_error <= 1'b0;
        else
            r_resp_error <= w_accept && w_trap;
    end
`else
    assign w_trap     = 1'b0;
    assign resp_error = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_trap)
                        w_next = S_RESP;
                    else if (req_write && w_req_word)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_last)
                    w_next = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane selection masks low address bits down to natural alignment.
    always_comb begin
        w_lane = 2'b00;
        unique case (r_size)
            2'b00:   w_lane = r_off;
            2'b01:   w_lane = {r_off[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end

    assign w_shamt = {w_lane, 3'b000};
    assign w_shift = mem_rdata >> w_shamt;

    always_comb begin
        w_load = mem_rdata;
        w_mask = 32'hFFFF_FFFF;
        unique case (r_size)
            2'b00: begin
                w_load = {{24{~r_unsigned & w_shift[7]}}, w_shift[7:0]};
                w_mask = 32'h0000_00FF << w_shamt;
            end
            2'b01: begin
                w_load = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
                w_mask = 32'h0000_FFFF << w_shamt;
            end
            default: begin
                w_load = mem_rdata;
                w_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= 3'd0;
            r_write       <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_off         <= 2'b00;
            r_wdata       <= 32'd0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= 32'd0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'd0;
        end else begin
            r_mem_read   <= (w_next == S_READ);
            r_mem_write  <= (w_next == S_WRITE);
            r_resp_valid <= (w_next == S_RESP);
            r_resp_rdata <= 32'd0;
            if (w_accept) begin
                r_write       <= req_write;
                r_size        <= req_size;
                r_unsigned    <= req_unsigned;
                r_off         <= req_addr[1:0];
                r_wdata       <= req_wdata;
                r_mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                if (req_write && w_req_word)
                    r_mem_wdata <= req_wdata;
            end
            if (r_state == S_READ)
                r_cnt <= w_rd_last ? 3'd0 : r_cnt + 3'd1;
            if (w_rd_last) begin
                if (r_write)
                    r_mem_wdata <= w_merged;
                else
                    r_resp_rdata <= w_load;
            end
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus latency/reset sequences.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_error, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_address;

    logic        req_valid3, req_ready3, req_write3, req_unsigned3;
    logic [1:0]  req_size3;
    logic [7:0]  req_addr3;
    logic [31:0] req_wdata3;
    logic        resp_valid3, resp_error3, mem_read3, mem_write3;
    logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
    logic [7:0]  mem_address3;

    logic [31:0] mem  [64];
    logic [31:0] mem3 [64];

    assign mem_rdata  = mem[mem_address[7:2]];
    assign mem_rdata3 = mem3[mem_address3[7:2]];

    always @(posedge clk) begin
        if (mem_write)  mem[mem_address[7:2]]   <= mem_wdata;
        if (mem_write3) mem3[mem_address3[7:2]] <= mem_wdata3;
    end

    mem_access_unit #(.ADDR_WIDTH(8), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ADDR_WIDTH(8), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write3), .req_size(req_size3),
        .req_unsigned(req_unsigned3), .req_addr(req_addr3),
        .req_wdata(req_wdata3),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
        .resp_error(resp_error3),
        .mem_read(mem_read3), .mem_write(mem_write3),
        .mem_address(mem_address3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [7:0]  ad;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          nrd;
        int          nwr;
        int          rc;
        logic [7:0]  ma;
        logic [31:0] mw;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic un,
                                logic [7:0] ad, logic [31:0] wd,
                                logic [31:0] rd, logic er, int nrd,
                                int nwr, int rc, logic [7:0] ma,
                                logic [31:0] mw);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.ad = ad; v.wd = wd;
        v.rd = rd; v.er = er; v.nrd = nrd; v.nwr = nwr; v.rc = rc;
        v.ma = ma; v.mw = mw;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        logic [31:0] rd = 32'd0;
        logic        er = 1'b0;
        logic [7:0]  ma = 8'd0;
        logic [31:0] mw = 32'd0;
        int nrd = 0, nwr = 0, rc = 0, both = 0;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz;
        req_unsigned = v.un; req_addr = v.ad; req_wdata = v.wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~v.wr; req_size = 2'b00;
        req_unsigned = ~v.un; req_addr = 8'h3C; req_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both++;
            if (mem_read) begin nrd++; ma = mem_address; end
            if (mem_write) begin nwr++; ma = mem_address; mw = mem_wdata; end
            if (resp_valid) begin
                rc = c; rd = resp_rdata; er = resp_error;
                break;
            end
        end
        chk($sformatf("v%0d resp_cycle", idx), rc, v.rc);
        chk($sformatf("v%0d rdata", idx), rd, v.rd);
        chk($sformatf("v%0d error", idx), {31'd0, er}, {31'd0, v.er});
        chk($sformatf("v%0d n_read", idx), nrd, v.nrd);
        chk($sformatf("v%0d n_write", idx), nwr, v.nwr);
        chk($sformatf("v%0d rd_wr_overlap", idx), both, 0);
        if (v.nrd + v.nwr > 0)
            chk($sformatf("v%0d mem_addr", idx), {24'd0, ma}, {24'd0, v.ma});
        if (v.nwr > 0)
            chk($sformatf("v%0d mem_wdata", idx), mw, v.mw);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nrd, nwr, rdyhi, rc;
        logic [31:0] rd;
        logic [7:0]  ra;

        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        mem3[8] = 32'h8BADF00D;
        mem3[9] = 32'h55555555;

        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        req_valid3 = 0; req_write3 = 0; req_size3 = 0; req_unsigned3 = 0;
        req_addr3 = 0; req_wdata3 = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst mem_address", {24'd0, mem_address}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_error", {31'd0, resp_error}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("post-rst req_ready3", {31'd0, req_ready3}, 32'd1);

        tv.push_back(mk(1, 2'd2, 0, 8'h14, 32'h12345678, 0, 0, 0, 1, 2, 8'h14, 32'h12345678));
        tv.push_back(mk(0, 2'd2, 0, 8'h14, 0, 32'h12345678, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(1, 2'd0, 0, 8'h15, 32'h000000AB, 0, 0, 1, 1, 3, 8'h14, 32'h1234AB78));
        tv.push_back(mk(0, 2'd2, 0, 8'h14, 0, 32'h1234AB78, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(0, 2'd0, 0, 8'h15, 0, 32'hFFFFFFAB, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(0, 2'd0, 1, 8'h15, 0, 32'h000000AB, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(0, 2'd1, 0, 8'h16, 0, 32'h00001234, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(1, 2'd1, 0, 8'h1A, 32'h00008001, 0, 0, 1, 1, 3, 8'h18, 32'h80010000));
        tv.push_back(mk(0, 2'd1, 0, 8'h1A, 0, 32'hFFFF8001, 0, 1, 0, 2, 8'h18, 0));
        tv.push_back(mk(0, 2'd1, 1, 8'h1A, 0, 32'h00008001, 0, 1, 0, 2, 8'h18, 0));
        tv.push_back(mk(0, 2'd0, 0, 8'h14, 0, 32'h00000078, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(0, 2'd0, 0, 8'h17, 0, 32'h00000012, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(1, 2'd0, 0, 8'h18, 32'hFFFFFF55, 0, 0, 1, 1, 3, 8'h18, 32'h80010055));
        tv.push_back(mk(0, 2'd2, 1, 8'h18, 0, 32'h80010055, 0, 1, 0, 2, 8'h18, 0));
        tv.push_back(mk(0, 2'd0, 0, 8'h1B, 0, 32'hFFFFFF80, 0, 1, 0, 2, 8'h18, 0));
        tv.push_back(mk(1, 2'd3, 0, 8'h1C, 32'hCAFEF00D, 0, 0, 0, 1, 2, 8'h1C, 32'hCAFEF00D));
        tv.push_back(mk(0, 2'd3, 0, 8'h1C, 0, 32'hCAFEF00D, 0, 1, 0, 2, 8'h1C, 0));
`ifdef MAU_MISALIGN_TRAP_EN
        tv.push_back(mk(0, 2'd2, 0, 8'h15, 0, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 2'd1, 0, 8'h17, 0, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 2'd2, 0, 8'h1D, 32'h11223344, 0, 1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 2'd2, 0, 8'h1C, 0, 32'hCAFEF00D, 0, 1, 0, 2, 8'h1C, 0));
`else
        tv.push_back(mk(0, 2'd2, 0, 8'h15, 0, 32'h1234AB78, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(0, 2'd1, 0, 8'h17, 0, 32'h00001234, 0, 1, 0, 2, 8'h14, 0));
        tv.push_back(mk(1, 2'd2, 0, 8'h1D, 32'h11223344, 0, 0, 0, 1, 2, 8'h1C, 32'h11223344));
        tv.push_back(mk(0, 2'd2, 0, 8'h1C, 0, 32'h11223344, 0, 1, 0, 2, 8'h1C, 0));
`endif

        foreach (tv[i]) run(tv[i], i);

        // Latency 3 load while a competing store request stays asserted.
        @(negedge clk);
        req_valid3 = 1'b1; req_write3 = 1'b0; req_size3 = 2'd2;
        req_addr3 = 8'h20; req_unsigned3 = 1'b0;
        @(posedge clk);
        #1;
        req_write3 = 1'b1; req_addr3 = 8'h24; req_wdata3 = 32'hFFFFFFFF;
        nrd = 0; nwr = 0; rdyhi = 0; rc = 0; rd = 32'd0; ra = 8'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read3) begin nrd++; ra = mem_address3; end
            if (mem_write3) nwr++;
            if (req_ready3) rdyhi++;
            if (resp_valid3) begin
                rc = c; rd = resp_rdata3; req_valid3 = 1'b0;
                break;
            end
        end
        req_valid3 = 1'b0;
        chk("rl3 resp_cycle", rc, 4);
        chk("rl3 n_read", nrd, 3);
        chk("rl3 n_write", nwr, 0);
        chk("rl3 ready_during_op", rdyhi, 0);
        chk("rl3 rdata", rd, 32'h8BADF00D);
        chk("rl3 mem_addr", {24'd0, ra}, 32'h20);
        nwr = 0; nrd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_write3) nwr++;
            if (mem_read3) nrd++;
        end
        chk("rl3 ignored_req_write", nwr, 0);
        chk("rl3 ignored_req_read", nrd, 0);
        chk("rl3 mem3[9]", mem3[9], 32'h55555555);

        // Reset while a sub-word store is still reading: no write may follow.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 8'h14; req_wdata = 32'h00000099; req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abortA read", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abortA mem_write", {31'd0, mem_write}, 32'd0);
        chk("abortA resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abortA ready_in_rst", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abortA ready_after", {31'd0, req_ready}, 32'd1);
        chk("abortA resp_valid2", {31'd0, resp_valid}, 32'd0);
        chk("abortA mem_word", mem[5], 32'h1234AB78);

        // Reset during the write cycle of a sub-word store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 8'h14; req_wdata = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abortB in_write", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abortB mem_write", {31'd0, mem_write}, 32'd0);
        chk("abortB resp_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abortB ready_after", {31'd0, req_ready}, 32'd1);
        rc = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || mem_write || mem_read) rc++;
            @(negedge clk);
        end
        chk("abortB quiet", rc, 0);
        chk("abortB mem_word", mem[5], 32'h1234AB99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
